// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for n slices: clog2(n), never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full-subtractor cell: d = x - y - bi with borrow-out bo.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor {bout, diff} = a - b - bin, SLICE bits per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  if ((WIDTH < 1) || (SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
    $error("serial_subtractor: SLICE must divide WIDTH and both must be >= 1");
  end

  state_e           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic             borrow_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;

  logic [SLICE:0]   bc_s;
  logic [SLICE-1:0] slice_d_s;
  logic [WIDTH-1:0] res_next_s;

  assign bc_s[0] = borrow_r;

  for (genvar i = 0; i < SLICE; i++) begin : g_cell
    fs_cell u_cell (
      .x  (a_sh_r[i]),
      .y  (b_sh_r[i]),
      .bi (bc_s[i]),
      .d  (slice_d_s[i]),
      .bo (bc_s[i+1])
    );
  end

  // New slice enters at the top so the result fills LSB-first.
  assign res_next_s = (res_sh_r >> SLICE) | (WIDTH'(slice_d_s) << (WIDTH - SLICE));

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_r;
  assign ovf = ovf_r;
`endif

  // Control FSM, operand/result shifting and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      res_sh_r <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= {WIDTH{1'b0}};
      bout_r   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            res_sh_r <= {WIDTH{1'b0}};
            borrow_r <= bin;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            state_r  <= ST_RUN;
          end else begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_r   <= a_sh_r >> SLICE;
          b_sh_r   <= b_sh_r >> SLICE;
          res_sh_r <= res_next_s;
          borrow_r <= bc_s[SLICE];
          cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_CNT) begin
            diff_r  <= res_next_s;
            bout_r  <= bc_s[SLICE];
`ifdef SERIAL_SUB_OVF_EN
            // The MSB is the top cell of the final slice.
            ovf_r   <= bc_s[SLICE-1] ^ bc_s[SLICE];
`endif
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: SLICE=1 and SLICE=4 instances, WIDTH=8.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start1;
  logic         start4;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy1, done1, bout1;
  logic         busy4, done4, bout4;
  logic [W-1:0] diff1, diff4;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf1, ovf4;
`endif

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W), .SLICE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .bin(bin),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_subtractor #(.WIDTH(W), .SLICE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .bin(bin),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected held outputs per instance (0: SLICE=1, 1: SLICE=4).
  logic [W-1:0] held_diff [2];
  logic         held_bout [2];
  logic         held_ovf  [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                         output logic [W-1:0] d, output logic bo, output logic ov);
    int r;
    int sr;
    r  = int'(av) - int'(bv) - int'(binv);
    sr = int'($signed(av)) - int'($signed(bv)) - int'(binv);
    bo = (r < 0);
    d  = W'(r + (1 << W));
    ov = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
  endtask

  function automatic int lat(input int sel);
    return (sel == 0) ? W : W / 4;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start1 = v;
    else          start4 = v;
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy1 : busy4;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 0) ? done1 : done4;
  endfunction
  function automatic logic [W-1:0] get_diff(input int sel);
    return (sel == 0) ? diff1 : diff4;
  endfunction
  function automatic logic get_bout(input int sel);
    return (sel == 0) ? bout1 : bout4;
  endfunction

  task automatic check_outputs(input int sel, input string tag);
    check_eq({tag, "_diff"}, 32'(get_diff(sel)), 32'(held_diff[sel]));
    check_eq({tag, "_bout"}, 32'(get_bout(sel)), 32'(held_bout[sel]));
`ifdef SERIAL_SUB_OVF_EN
    check_eq({tag, "_ovf"}, 32'((sel == 0) ? ovf1 : ovf4), 32'(held_ovf[sel]));
`endif
  endtask

  // Checks one operation cycle-by-cycle from the capture edge to done.
  task automatic run_op(input int sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic binv, input bit poke);
    int n;
    logic [W-1:0] ed;
    logic eb, eo;
    n = lat(sel);
    ref_sub(av, bv, binv, ed, eb, eo);
    @(negedge clk);
    a = av; b = bv; bin = binv;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (int i = 0; i <= n; i++) begin
      if (poke && i == 1) begin
        set_start(sel, 1'b1);
        a = 8'hFF;
      end
      if (poke && i == 2) set_start(sel, 1'b0);
      check_eq($sformatf("busy_s%0d_c%0d", sel, i), 32'(get_busy(sel)), 32'(i < n));
      check_eq($sformatf("done_s%0d_c%0d", sel, i), 32'(get_done(sel)), 32'(i == n));
      if (i == n) begin
        held_diff[sel] = ed;
        held_bout[sel] = eb;
        held_ovf[sel]  = eo;
        check_outputs(sel, $sformatf("res_s%0d_%02h_%02h_%0d", sel, av, bv, binv));
      end else if (i == n / 2) begin
        check_outputs(sel, $sformatf("hold_s%0d", sel));
      end
      if (i < n) @(negedge clk);
    end
    set_start(sel, 1'b0);
    @(negedge clk);
    check_eq($sformatf("done_clr_s%0d", sel), 32'(get_done(sel)), 32'(0));
    check_eq($sformatf("idle_s%0d", sel), 32'(get_busy(sel)), 32'(0));
  endtask

  // Three operations with start held high throughout.
  task automatic run_b2b(input int sel);
    int n;
    logic [W-1:0] oa [3];
    logic [W-1:0] ob [3];
    logic         oc [3];
    logic [W-1:0] ed;
    logic eb, eo;
    n = lat(sel);
    for (int j = 0; j < 3; j++) begin
      oa[j] = W'($urandom); ob[j] = W'($urandom); oc[j] = 1'($urandom);
    end
    @(negedge clk);
    a = oa[0]; b = ob[0]; bin = oc[0];
    set_start(sel, 1'b1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      ref_sub(oa[j], ob[j], oc[j], ed, eb, eo);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      for (int i = 0; i <= n; i++) begin
        check_eq($sformatf("b2b_busy_s%0d_op%0d_c%0d", sel, j, i), 32'(get_busy(sel)), 32'(i < n));
        check_eq($sformatf("b2b_done_s%0d_op%0d_c%0d", sel, j, i), 32'(get_done(sel)), 32'(i == n));
        if (i == n) begin
          held_diff[sel] = ed;
          held_bout[sel] = eb;
          held_ovf[sel]  = eo;
          check_outputs(sel, $sformatf("b2b_s%0d_op%0d", sel, j));
          if (j < 2) begin
            a = oa[j+1]; b = ob[j+1]; bin = oc[j+1];
          end else begin
            set_start(sel, 1'b0);
          end
        end else begin
          @(negedge clk);
        end
      end
    end
    @(negedge clk);
    check_eq($sformatf("b2b_end_done_s%0d", sel), 32'(get_done(sel)), 32'(0));
  endtask

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      held_diff[s] = '0;
      held_bout[s] = 1'b0;
      held_ovf[s]  = 1'b0;
    end
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_eq($sformatf("rst_busy_s%0d", s), 32'(get_busy(s)), 32'(0));
      check_eq($sformatf("rst_done_s%0d", s), 32'(get_done(s)), 32'(0));
      check_outputs(s, "rst");
    end
    rst_n = 1'b1;

    // Directed cases.
    run_op(0, 8'h05, 8'h03, 1'b0, 1'b0);
    run_op(0, 8'h03, 8'h05, 1'b0, 1'b0);
    run_op(0, 8'h00, 8'h00, 1'b1, 1'b0);
    run_op(1, 8'hA5, 8'h5A, 1'b1, 1'b1);
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b0);
    run_op(1, 8'h7F, 8'hFF, 1'b0, 1'b0);
    run_op(1, 8'h10, 8'h01, 1'b0, 1'b0);
    run_op(0, 8'hFF, 8'hFF, 1'b1, 1'b1);

    // Back-to-back on both slice configurations.
    run_b2b(0);
    run_b2b(1);

    // Reset during a SLICE=1 run: asserted at the fourth edge after capture.
    @(negedge clk);
    a = 8'h5C; b = 8'h21; bin = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    reset_model();
    rst_n = 1'b1;
    check_eq("midrst_busy", 32'(busy1), 32'(0));
    check_eq("midrst_done", 32'(done1), 32'(0));
    check_outputs(0, "midrst");
    check_outputs(1, "midrst_other");
    saw_done = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done1 || busy1) saw_done = 1'b1;
    end
    check_eq("midrst_no_done", 32'(saw_done), 32'(0));
    run_op(0, 8'h5C, 8'h21, 1'b0, 1'b0);

    // Randomized operations on both instances.
    for (int k = 0; k < 24; k++) begin
      run_op(k % 2, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
